avr_cpu_progmem_arbiter: RTL and testbench

- Shares the single program memory port between three requesters:
  - the instruction fetch stage;
  - the LPM (load-program-memory) byte-read path of the execute stage;
  - an external loader that writes program words.
- Sits between the fetch stage and the program memory. It steals memory cycles for LPM reads and loader writes.
- On every stolen cycle it raises fetch_stall, so the fetch stage holds its PC and opcode and replays its address.

---
 rtl/avr_cpu_progmem_arbiter.sv | 112 +++++++++++
 tb/tb_avr_cpu_progmem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/avr_cpu_progmem_arbiter.sv
// Program memory port arbiter: shares one synchronous-read memory port between
// instruction fetch, LPM byte reads and the external program loader.
module avr_cpu_progmem_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [15:0]           fetch_data,
    output logic                  fetch_stall,
    input  logic                  lpm_req,
    input  logic [ADDR_WIDTH:0]   lpm_addr,
    output logic                  lpm_ack,
    output logic [7:0]            lpm_data,
    input  logic                  prog_mode,
    input  logic                  prog_req,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [15:0]           prog_wdata,
    output logic                  prog_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        LPM_DATA = 2'd1,
        PROG     = 2'd2,
        RESUME   = 2'd3
    } state_t;

    state_t state_r;
    state_t state_next_s;
    logic   lpm_sel_q;
    logic   lpm_sel_next_s;

    assign fetch_data = mem_rdata;

    // State register and latched LPM byte select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= FETCH;
            lpm_sel_q <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            lpm_sel_q <= lpm_sel_next_s;
        end
    end

    // Next-state and memory-port steering; reset forces the idle fetch view.
    always_comb begin
        state_next_s   = state_r;
        lpm_sel_next_s = lpm_sel_q;
        mem_addr       = fetch_addr;
        mem_we         = 1'b0;
        mem_wdata      = {DATA_WIDTH{1'b0}};
        fetch_stall    = 1'b0;
        lpm_ack        = 1'b0;
        lpm_data       = 8'h00;
        prog_ack       = 1'b0;
        if (rst) begin
            state_next_s = FETCH;
        end else begin
            case (state_r)
                FETCH: begin
                    if (prog_mode) begin
                        fetch_stall  = 1'b1;
                        state_next_s = PROG;
                    end else if (lpm_req) begin
                        mem_addr       = lpm_addr[ADDR_WIDTH:1];
                        fetch_stall    = 1'b1;
                        lpm_sel_next_s = lpm_addr[0];
                        state_next_s   = LPM_DATA;
                    end else begin
                        state_next_s = FETCH;
                    end
                end
                LPM_DATA: begin
                    // Memory returns the LPM word now; the port replays the fetch address.
                    lpm_ack      = 1'b1;
                    lpm_data     = lpm_sel_q ? mem_rdata[15:8] : mem_rdata[7:0];
                    fetch_stall  = 1'b1;
                    state_next_s = FETCH;
                end
                PROG: begin
                    fetch_stall = 1'b1;
                    if (!prog_mode) begin
                        state_next_s = RESUME;
                    end else if (prog_req) begin
                        mem_we    = 1'b1;
                        mem_addr  = prog_addr;
                        mem_wdata = prog_wdata;
                        prog_ack  = 1'b1;
                    end else begin
                        state_next_s = PROG;
                    end
                end
                RESUME: begin
                    fetch_stall  = 1'b1;
                    state_next_s = FETCH;
                end
                default: begin
                    fetch_stall  = 1'b1;
                    state_next_s = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avr_cpu_progmem_arbiter.sv
// Scoreboard bench for the program memory arbiter with a synchronous-read memory model.
module tb_avr_cpu_progmem_arbiter;

    logic        clk;
    logic        rst;
    logic [8:0]  fetch_addr;
    logic [15:0] fetch_data;
    logic        fetch_stall;
    logic        lpm_req;
    logic [9:0]  lpm_addr;
    logic        lpm_ack;
    logic [7:0]  lpm_data;
    logic        prog_mode;
    logic        prog_req;
    logic [8:0]  prog_addr;
    logic [15:0] prog_wdata;
    logic        prog_ack;
    logic [8:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] tb_mem [512];
    logic [15:0] ref_mem [512];
    logic        preload;

    logic [16:0] rd_q [$];
    logic [7:0]  lpm_q [$];
    int          checks;
    int          errors;

    avr_cpu_progmem_arbiter #(.ADDR_WIDTH(9), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .fetch_addr(fetch_addr), .fetch_data(fetch_data), .fetch_stall(fetch_stall),
        .lpm_req(lpm_req), .lpm_addr(lpm_addr), .lpm_ack(lpm_ack), .lpm_data(lpm_data),
        .prog_mode(prog_mode), .prog_req(prog_req), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .prog_ack(prog_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input logic [8:0] k);
        return (k == 9'd5) ? 16'hBEEF : (16'h0100 + {7'd0, k});
    endfunction

    // Synchronous-read program memory; the first edge loads the initial image.
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 512; k++) tb_mem[k] <= init_word(9'(k));
            mem_rdata <= init_word(mem_addr);
        end else begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            mem_rdata <= tb_mem[mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic lpm_issue(input logic [9:0] a);
        logic [15:0] w;
        lpm_req  = 1'b1;
        lpm_addr = a;
        w = ref_mem[a[9:1]];
        lpm_q.push_back(a[0] ? w[15:8] : w[7:0]);
    endtask

    // One clock cycle: check outputs at the falling edge, then advance past the rising edge.
    task automatic tick(input logic exp_stall, input logic [8:0] exp_addr,
                        input logic exp_we, input logic exp_lack);
        logic [16:0] e;
        logic [7:0]  b;
        @(negedge clk);
        check_eq("fetch_stall", {31'd0, fetch_stall}, {31'd0, exp_stall});
        check_eq("mem_addr", {23'd0, mem_addr}, {23'd0, exp_addr});
        check_eq("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        check_eq("prog_ack", {31'd0, prog_ack}, {31'd0, exp_we});
        check_eq("lpm_ack", {31'd0, lpm_ack}, {31'd0, exp_lack});
        if (exp_we) check_eq("mem_wdata", {16'd0, mem_wdata}, {16'd0, prog_wdata});
        if (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            if (e[16]) check_eq("fetch_data", {16'd0, fetch_data}, {16'd0, e[15:0]});
        end
        if (exp_lack) begin
            check_eq("lpm_pending", 32'(lpm_q.size() > 0), 32'd1);
            if (lpm_q.size() > 0) begin
                b = lpm_q.pop_front();
                check_eq("lpm_data", {24'd0, lpm_data}, {24'd0, b});
            end
        end
        if (exp_we) begin
            rd_q.push_back(17'd0);
            ref_mem[exp_addr] = prog_wdata;
        end else begin
            rd_q.push_back({1'b1, ref_mem[exp_addr]});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0; errors = 0;
        for (int k = 0; k < 512; k++) ref_mem[k] = init_word(9'(k));
        rst = 1'b1; preload = 1'b1;
        fetch_addr = 9'd0; lpm_req = 1'b0; lpm_addr = 10'd0;
        prog_mode = 1'b0; prog_req = 1'b0; prog_addr = 9'd0; prog_wdata = 16'd0;

        tick(1'b0, 9'd0, 1'b0, 1'b0);
        preload = 1'b0;
        tick(1'b0, 9'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Plain fetch stream.
        for (int a = 0; a < 4; a++) begin
            fetch_addr = 9'(a);
            tick(1'b0, 9'(a), 1'b0, 1'b0);
        end

        // Single LPM reads, high then low byte of word 5.
        lpm_issue(10'h00B);
        tick(1'b1, 9'd5, 1'b0, 1'b0);
        tick(1'b1, 9'd3, 1'b0, 1'b1);
        lpm_req = 1'b0;
        tick(1'b0, 9'd3, 1'b0, 1'b0);
        lpm_issue(10'h00A);
        tick(1'b1, 9'd5, 1'b0, 1'b0);
        tick(1'b1, 9'd3, 1'b0, 1'b1);
        lpm_req = 1'b0;
        tick(1'b0, 9'd3, 1'b0, 1'b0);

        // Back-to-back LPM with the request held high.
        for (int i = 0; i < 3; i++) begin
            lpm_issue(10'h040 + 10'(i * 3));
            tick(1'b1, 9'h020 + 9'((i * 3) >> 1), 1'b0, 1'b0);
            tick(1'b1, 9'd3, 1'b0, 1'b1);
        end
        lpm_req = 1'b0;
        tick(1'b0, 9'd3, 1'b0, 1'b0);

        // Programming burst, a request ignored on exit, then readback.
        fetch_addr = 9'd4;
        prog_mode = 1'b1;
        tick(1'b1, 9'd4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            prog_req = 1'b1;
            prog_addr = 9'd10 + 9'(i);
            prog_wdata = 16'hA000 + 16'(i);
            tick(1'b1, 9'd10 + 9'(i), 1'b1, 1'b0);
        end
        prog_mode = 1'b0;
        prog_addr = 9'd20;
        prog_wdata = 16'hDEAD;
        tick(1'b1, 9'd4, 1'b0, 1'b0);
        prog_req = 1'b0;
        tick(1'b1, 9'd4, 1'b0, 1'b0);
        tick(1'b0, 9'd4, 1'b0, 1'b0);
        for (int a = 10; a < 15; a++) begin
            fetch_addr = 9'(a);
            tick(1'b0, 9'(a), 1'b0, 1'b0);
        end
        fetch_addr = 9'd20;
        tick(1'b0, 9'd20, 1'b0, 1'b0);
        fetch_addr = 9'd21;
        tick(1'b0, 9'd21, 1'b0, 1'b0);

        // prog_mode and lpm_req together: programming wins, LPM served after resume.
        fetch_addr = 9'd6;
        prog_mode = 1'b1;
        lpm_issue(10'h007);
        tick(1'b1, 9'd6, 1'b0, 1'b0);
        tick(1'b1, 9'd6, 1'b0, 1'b0);
        tick(1'b1, 9'd6, 1'b0, 1'b0);
        prog_mode = 1'b0;
        tick(1'b1, 9'd6, 1'b0, 1'b0);
        tick(1'b1, 9'd6, 1'b0, 1'b0);
        tick(1'b1, 9'd3, 1'b0, 1'b0);
        tick(1'b1, 9'd6, 1'b0, 1'b1);
        lpm_req = 1'b0;
        tick(1'b0, 9'd6, 1'b0, 1'b0);

        // Asynchronous reset while in LPM_DATA.
        lpm_issue(10'h009);
        tick(1'b1, 9'd4, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("rst_lpm_ack", {31'd0, lpm_ack}, 32'd0);
        check_eq("rst_lpm_stall", {31'd0, fetch_stall}, 32'd0);
        check_eq("rst_lpm_addr", {23'd0, mem_addr}, {23'd0, fetch_addr});
        lpm_q.delete();
        lpm_req = 1'b0;
        tick(1'b0, 9'd6, 1'b0, 1'b0);
        rst = 1'b0;
        tick(1'b0, 9'd6, 1'b0, 1'b0);

        // Asynchronous reset while a write is presented in PROG.
        prog_mode = 1'b1;
        tick(1'b1, 9'd6, 1'b0, 1'b0);
        prog_req = 1'b1;
        prog_addr = 9'd30;
        prog_wdata = 16'h1234;
        #1;
        check_eq("prog_we_before_rst", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_prog_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_prog_ack", {31'd0, prog_ack}, 32'd0);
        check_eq("rst_prog_wdata", {16'd0, mem_wdata}, 32'd0);
        check_eq("rst_prog_stall", {31'd0, fetch_stall}, 32'd0);
        prog_mode = 1'b0;
        prog_req = 1'b0;
        tick(1'b0, 9'd6, 1'b0, 1'b0);
        rst = 1'b0;
        tick(1'b0, 9'd6, 1'b0, 1'b0);
        fetch_addr = 9'd30;
        tick(1'b0, 9'd30, 1'b0, 1'b0);
        tick(1'b0, 9'd30, 1'b0, 1'b0);

        check_eq("lpm_q_drained", 32'(lpm_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
